// File: rtl/mem_stage_lsu.sv
// ---------------------------------------------------------------------------
// mem_stage_lsu
//   MEM-stage load/store unit. Sits between the EX/MEM and MEM/WB registers.
//   It issues one access per memory instruction on a req/ready data bus with
//   variable latency, builds the store strobes and the lane-replicated store
//   data, and aligns and extends the load result for MEM/WB. The upstream
//   pipeline is frozen through stall_out_Mem while an access is outstanding.
//
// Parameters
//   TIMEOUT            REQ cycles without dmem_ready before a bus error (>=1)
//
// Ports
//   clk_Mem            in   1   stage clock, rising edge
//   rst_Mem            in   1   synchronous active-high reset
//   valid_in_Mem       in   1   EX/MEM holds a live instruction
//   MemRead_in_Mem     in   1   load
//   MemWrite_in_Mem    in   1   store (wins over MemRead)
//   funct3_in_Mem      in   3   000 B, 001 H, 010 W, 100 BU, 101 HU, else W
//   ALU_in_Mem         in   32  effective byte address
//   Rs2_data_in_Mem    in   32  store data
//   dmem_req           out  1   bus request (registered)
//   dmem_we            out  1   write enable (registered)
//   dmem_addr          out  32  word-aligned address (registered)
//   dmem_wdata         out  32  lane-replicated store data (registered)
//   dmem_wstrb         out  4   byte enables, zero for loads (registered)
//   dmem_ready         in   1   bus completes the access this cycle
//   dmem_rdata         in   32  read data, valid with dmem_ready
//   Dmem_data_out_Mem  out  32  extended load result
//   stall_out_Mem      out  1   pipeline freeze (combinational)
//   misalign_out_Mem   out  1   misaligned access flag (combinational)
//   bus_err_out_Mem    out  1   timeout flag, high only in DONE
// ---------------------------------------------------------------------------
module mem_stage_lsu #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk_Mem,
  input  logic        rst_Mem,
  input  logic        valid_in_Mem,
  input  logic        MemRead_in_Mem,
  input  logic        MemWrite_in_Mem,
  input  logic [2:0]  funct3_in_Mem,
  input  logic [31:0] ALU_in_Mem,
  input  logic [31:0] Rs2_data_in_Mem,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] Dmem_data_out_Mem,
  output logic        stall_out_Mem,
  output logic        misalign_out_Mem,
  output logic        bus_err_out_Mem
);

  // Wide enough to hold TIMEOUT itself, so TIMEOUT=1 still gets one bit.
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic        r_req;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic [1:0]  r_off;
  logic [2:0]  r_funct3;
  logic        r_is_load;
  logic [31:0] r_dout;
  logic        r_bus_err;
  logic [CW-1:0] r_cnt;

  // -------------------------------------------------------------------------
  // Request decode (from EX/MEM, only acted on in IDLE)
  // -------------------------------------------------------------------------
  logic        w_mem_op;
  logic        w_is_store;
  logic        w_size_byte;
  logic        w_size_half;
  logic        w_size_word;
  logic        w_misalign;
  logic        w_access;

  assign w_mem_op    = valid_in_Mem & (MemRead_in_Mem | MemWrite_in_Mem);
  assign w_is_store  = MemWrite_in_Mem;
  // Size is carried by funct3[1:0]; bit 2 only selects zero-extension for
  // loads. Every encoding outside B/H/BU/HU lands on the word size.
  assign w_size_byte = (funct3_in_Mem[1:0] == 2'b00);
  assign w_size_half = (funct3_in_Mem[1:0] == 2'b01);
  assign w_size_word = ~w_size_byte & ~w_size_half;

  assign w_misalign  = w_mem_op & ((w_size_half & ALU_in_Mem[0]) |
                                   (w_size_word & (ALU_in_Mem[1:0] != 2'b00)));
  assign w_access    = w_mem_op & ~w_misalign;

  // Store lane formatting
  logic [31:0] w_wdata_fmt;
  logic [3:0]  w_wstrb_fmt;

  always_comb begin
    w_wdata_fmt = Rs2_data_in_Mem;
    w_wstrb_fmt = 4'b1111;
    if (w_size_byte) begin
      w_wdata_fmt = {4{Rs2_data_in_Mem[7:0]}};
      w_wstrb_fmt = 4'b0001 << ALU_in_Mem[1:0];
    end else if (w_size_half) begin
      w_wdata_fmt = {2{Rs2_data_in_Mem[15:0]}};
      w_wstrb_fmt = 4'b0011 << ALU_in_Mem[1:0];
    end
  end

  // -------------------------------------------------------------------------
  // Load alignment and extension, from the offset/funct3 captured at issue
  // -------------------------------------------------------------------------
  logic [7:0]  w_ld_byte;
  logic [15:0] w_ld_half;
  logic [31:0] w_ld_ext;

  assign w_ld_byte = dmem_rdata[{r_off, 3'b000} +: 8];
  assign w_ld_half = dmem_rdata[{r_off[1], 4'b0000} +: 16];

  always_comb begin
    w_ld_ext = dmem_rdata;
    case (r_funct3)
      3'b000:  w_ld_ext = {{24{w_ld_byte[7]}}, w_ld_byte};
      3'b001:  w_ld_ext = {{16{w_ld_half[15]}}, w_ld_half};
      3'b100:  w_ld_ext = {24'd0, w_ld_byte};
      3'b101:  w_ld_ext = {16'd0, w_ld_half};
      default: w_ld_ext = dmem_rdata;
    endcase
  end

  // -------------------------------------------------------------------------
  // Control FSM
  // -------------------------------------------------------------------------
  logic w_start;
  logic w_complete;
  logic w_timeout;
  logic w_stall;

  always_ff @(posedge clk_Mem) begin
    if (rst_Mem) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_stall      = 1'b0;
    w_start      = 1'b0;
    w_complete   = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_stall = w_access;
        if (w_access) begin
          w_start      = 1'b1;
          w_state_next = S_REQ;
        end
      end
      S_REQ: begin
        w_stall = 1'b1;
        // A response on the last allowed cycle still counts as success.
        if (dmem_ready) begin
          w_complete   = 1'b1;
          w_state_next = S_DONE;
        end else if (r_cnt == CNT_LAST) begin
          w_timeout    = 1'b1;
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        // One free cycle lets EX/MEM and MEM/WB advance; the instruction
        // still visible on the inputs is the one just served, so no re-issue.
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Bus, result and counter registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_Mem) begin
    if (rst_Mem) begin
      r_req     <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= 32'd0;
      r_wdata   <= 32'd0;
      r_wstrb   <= 4'd0;
      r_off     <= 2'd0;
      r_funct3  <= 3'd0;
      r_is_load <= 1'b0;
      r_dout    <= 32'd0;
      r_bus_err <= 1'b0;
      r_cnt     <= '0;
    end else begin
      // Set on the timeout transition, so it is high exactly in DONE.
      r_bus_err <= w_timeout;

      if (w_start) begin
        r_req     <= 1'b1;
        r_we      <= w_is_store;
        r_addr    <= {ALU_in_Mem[31:2], 2'b00};
        r_wdata   <= w_is_store ? w_wdata_fmt : 32'd0;
        r_wstrb   <= w_is_store ? w_wstrb_fmt : 4'd0;
        r_off     <= ALU_in_Mem[1:0];
        r_funct3  <= funct3_in_Mem;
        r_is_load <= ~w_is_store;
      end

      if (w_complete) begin
        r_req <= 1'b0;
        if (r_is_load) begin
          r_dout <= w_ld_ext;
        end
      end

      if (w_timeout) begin
        r_req  <= 1'b0;
        r_dout <= 32'd0;
      end

      if (r_state == S_REQ) begin
        r_cnt <= r_cnt + 1'b1;
      end else if (r_state == S_DONE) begin
        r_cnt <= '0;
      end
    end
  end

  assign dmem_req          = r_req;
  assign dmem_we           = r_we;
  assign dmem_addr         = r_addr;
  assign dmem_wdata        = r_wdata;
  assign dmem_wstrb        = r_wstrb;
  assign Dmem_data_out_Mem = r_dout;
  assign stall_out_Mem     = w_stall;
  assign misalign_out_Mem  = w_misalign;
  assign bus_err_out_Mem   = r_bus_err;

endmodule
